// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with a forwarding store buffer
// Stores are posted into a FIFO and drained in the background; load misses take priority.
module dmem_responder #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmem_we,
    input  logic        dmem_re,
    input  logic [31:0] alu_out,
    input  logic [31:0] dmem_wd,
    output logic [31:0] dmem_rd,
    output logic        stall,
    output logic        buffer_empty,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t        state;
    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic          load;
    logic          hit;
    logic          load_miss;
    logic          full;
    logic          push;
    logic          pop;
    logic          read_done;
    logic [31:0]   fwd_data;
    logic [PW-1:0] idx;

    // Walk oldest to newest so the youngest matching store wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((i < int'(count)) && (addr_q[idx] == alu_out[31:2])) begin
                hit      = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign load         = dmem_re & ~dmem_we;
    assign load_miss    = load & ~hit;
    assign full         = (count == CNT_FULL);
    assign push         = dmem_we & ~full;
    assign pop          = (state == WRITE) & mem_ack;
    assign read_done    = (state == READ) & mem_ack;
    assign stall        = ~reset & ((dmem_we & full) | (load_miss & ~read_done));
    assign buffer_empty = (count == '0) & (state != WRITE);

    always_comb begin
        dmem_rd = '0;
        if (!reset && load) begin
            if (hit)
                dmem_rd = fwd_data;
            else if (read_done)
                dmem_rd = mem_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[wr_ptr] <= alu_out[31:2];
            data_q[wr_ptr] <= dmem_wd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (!push && pop)
                count <= count - CNT_ONE;

            case (state)
                IDLE: begin
                    if (load_miss) begin
                        state    <= READ;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {alu_out[31:2], 2'b00};
                    end else if (count != '0) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {addr_q[rd_ptr], 2'b00};
                        mem_wdata <= data_q[rd_ptr];
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dmem_we = 1'b0;
    logic        dmem_re = 1'b0;
    logic [31:0] alu_out = '0;
    logic [31:0] dmem_wd = '0;
    logic [31:0] dmem_rd;
    logic        stall;
    logic        buffer_empty;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'hBAD0_BAD0;

    int          n_cmp = 0;
    int          n_fail = 0;
    bit          auto_ack = 1'b0;
    int          lat = 2;
    int          age = 0;
    logic [31:0] next_rdata = '0;
    logic [64:0] exp_q[$];
    logic [64:0] obs_q[$];

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset), .dmem_we(dmem_we), .dmem_re(dmem_re),
        .alu_out(alu_out), .dmem_wd(dmem_wd), .dmem_rd(dmem_rd), .stall(stall),
        .buffer_empty(buffer_empty), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    // Advance one cycle; the backing-memory model acks after 'lat' request cycles.
    task automatic tick();
        @(posedge clock);
        #1;
        if (mem_ack) begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
            age       = 0;
        end else if (mem_req && auto_ack) begin
            age++;
            if (age >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_we ? 32'hBAD1_BAD1 : next_rdata;
                obs_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : next_rdata});
            end
        end else if (!mem_req) begin
            age = 0;
        end
    endtask

    task automatic idle_inputs();
        dmem_we = 1'b0;
        dmem_re = 1'b0;
        alu_out = '0;
        dmem_wd = '0;
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        auto_ack = 1'b1;
        lat = 2;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            idle_inputs();
            #4;
            if (buffer_empty && !mem_req && !mem_ack) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: buffer_empty=%b mem_req=%b, required 1 and 0", name, buffer_empty, mem_req);
        end
    endtask

    task automatic test_reset();
        tick(); reset = 1'b1; idle_inputs(); auto_ack = 1'b0; age = 0; #4;
        tick(); #4;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b need 0", stall); end
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b need 0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b need 0", mem_we); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h need 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h need 0", mem_wdata); end
        n_cmp++; if (dmem_rd !== 32'h0) begin n_fail++; $display("FAIL reset_dmem_rd: got %h need 0", dmem_rd); end
        n_cmp++; if (buffer_empty !== 1'b1) begin n_fail++; $display("FAIL reset_buffer_empty: got %b need 1", buffer_empty); end
        tick(); reset = 1'b0; #4;
        n_cmp++; if (buffer_empty !== 1'b1) begin n_fail++; $display("FAIL post_reset_empty: got %b need 1", buffer_empty); end
    endtask

    task automatic test_store_fwd();
        logic [64:0] e, o;
        auto_ack = 1'b1; lat = 2;
        tick(); dmem_we = 1'b1; alu_out = 32'h100; dmem_wd = 32'hDEADBEEF; #4;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd_store_stall: got %b need 0", stall); end
        else exp_q.push_back({1'b1, 32'h100, 32'hDEADBEEF});
        tick(); dmem_we = 1'b0; dmem_re = 1'b1; alu_out = 32'h100; #4;
        n_cmp++; if (dmem_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fwd_data: got %h need deadbeef", dmem_rd); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall: got %b need 0", stall); end
        n_cmp++; if ((mem_req & ~mem_we) !== 1'b0) begin n_fail++; $display("FAIL fwd_no_read: mem_req=%b mem_we=%b, no read allowed", mem_req, mem_we); end
        tick(); dmem_re = 1'b0; #4;
        n_cmp++; if (dmem_rd !== 32'h0) begin n_fail++; $display("FAIL idle_dmem_rd: got %h need 0", dmem_rd); end
        drain("store_fwd");
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fwd_bus_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL fwd_bus: got %h need %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [64:0] e, o;
        auto_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); dmem_we = 1'b1; alu_out = 32'h1000 + 32'(4 * i); dmem_wd = 32'hA000_0000 + 32'(i); #4;
            n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_store%0d_stall: got %b need 0", i, stall); end
            else exp_q.push_back({1'b1, alu_out, dmem_wd});
        end
        tick(); alu_out = 32'h1010; dmem_wd = 32'hA000_0004; #4;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin tick(); #4; end
            n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_full_stall%0d: got %b need 1", k, stall); end
        end
        auto_ack = 1'b1; lat = 1;
        tick(); #4;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_cycle_stall: got %b need 1", stall); end
        tick(); #4;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_stall: got %b need 0", stall); end
        else exp_q.push_back({1'b1, 32'h1010, 32'hA000_0004});
        drain("back_to_back");
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_bus_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL b2b_bus: got %h need %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_load_miss();
        logic [64:0] e, o;
        int stalls = 0;
        bit done = 1'b0;
        auto_ack = 1'b1; lat = 3; next_rdata = 32'h12345678;
        tick(); dmem_re = 1'b1; alu_out = 32'h200; #4;
        exp_q.push_back({1'b0, 32'h200, 32'h12345678});
        for (int k = 0; k < 12 && !done; k++) begin
            if (k > 0) begin tick(); #4; end
            if (mem_ack) begin
                done = 1'b1;
                n_cmp++; if (dmem_rd !== 32'h12345678) begin n_fail++; $display("FAIL miss_data: got %h need 12345678", dmem_rd); end
                n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL miss_ack_stall: got %b need 0", stall); end
            end else if (stall) begin
                stalls++;
                n_cmp++; if (dmem_rd !== 32'h0) begin n_fail++; $display("FAIL miss_wait_rd: got %h need 0", dmem_rd); end
            end else begin
                done = 1'b1;
                n_cmp++; n_fail++; $display("FAIL miss_early_release: stall=0 before ack, need 1");
            end
        end
        n_cmp++; if (stalls != 3) begin n_fail++; $display("FAIL miss_stall_cycles: got %0d need 3", stalls); end
        drain("load_miss");
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL miss_bus_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL miss_bus: got %h need %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_same_word();
        logic [64:0] e, o;
        auto_ack = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick(); dmem_we = 1'b1; alu_out = 32'h40; dmem_wd = 32'(i); #4;
            n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL same_store%0d_stall: got %b need 0", i, stall); end
            else exp_q.push_back({1'b1, 32'h40, 32'(i)});
        end
        tick(); dmem_we = 1'b0; dmem_re = 1'b1; alu_out = 32'h43; #4;
        n_cmp++; if (dmem_rd !== 32'h2) begin n_fail++; $display("FAIL same_newest: got %h need 2", dmem_rd); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL same_load_stall: got %b need 0", stall); end
        drain("same_word");
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL same_bus_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL same_bus: got %h need %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_miss_priority();
        logic [64:0] e, o;
        bit done = 1'b0;
        auto_ack = 1'b0;
        tick(); dmem_we = 1'b1; alu_out = 32'h300; dmem_wd = 32'h33; #4;
        tick(); alu_out = 32'h304; dmem_wd = 32'h44; #4;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL prio_store_stall: got %b need 0", stall); end
        // Bus order: the in-flight write finishes, then the read jumps the remaining store.
        exp_q.push_back({1'b1, 32'h300, 32'h33});
        exp_q.push_back({1'b0, 32'h500, 32'h55AA55AA});
        exp_q.push_back({1'b1, 32'h304, 32'h44});
        tick(); dmem_we = 1'b0; dmem_re = 1'b1; alu_out = 32'h500; next_rdata = 32'h55AA55AA;
        auto_ack = 1'b1; lat = 1; #4;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL prio_miss_stall: got %b need 1", stall); end
        for (int k = 0; k < 12 && !done; k++) begin
            tick(); #4;
            if (mem_ack && !mem_we) begin
                done = 1'b1;
                n_cmp++; if (dmem_rd !== 32'h55AA55AA) begin n_fail++; $display("FAIL prio_data: got %h need 55aa55aa", dmem_rd); end
                n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL prio_ack_stall: got %b need 0", stall); end
                n_cmp++; if (buffer_empty !== 1'b0) begin n_fail++; $display("FAIL prio_empty_early: got %b need 0", buffer_empty); end
            end
        end
        n_cmp++; if (!done) begin n_fail++; $display("FAIL prio_read_timeout: no read ack, need one"); end
        drain("miss_priority");
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL prio_bus_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL prio_bus: got %h need %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [64:0] e, o;
        auto_ack = 1'b0;
        tick(); dmem_we = 1'b1; alu_out = 32'h600; dmem_wd = 32'h66; #4;
        tick(); alu_out = 32'h604; dmem_wd = 32'h77; #4;
        tick(); idle_inputs(); #4;
        n_cmp++; if ((mem_req & mem_we) !== 1'b1) begin n_fail++; $display("FAIL rst_mid_inflight: mem_req=%b mem_we=%b need 1 1", mem_req, mem_we); end
        tick(); reset = 1'b1; mem_ack = 1'b1; #4;
        tick(); reset = 1'b0; mem_ack = 1'b1; #4;
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b need 0", mem_req); end
        n_cmp++; if (buffer_empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty: got %b need 1", buffer_empty); end
        tick(); #4;
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack_req: got %b need 0", mem_req); end
        n_cmp++; if (buffer_empty !== 1'b1) begin n_fail++; $display("FAIL rst_late_ack_empty: got %b need 1", buffer_empty); end
        exp_q.delete(); obs_q.delete();
        auto_ack = 1'b1; lat = 1;
        tick(); dmem_we = 1'b1; alu_out = 32'h700; dmem_wd = 32'h99; #4;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_new_store_stall: got %b need 0", stall); end
        else exp_q.push_back({1'b1, 32'h700, 32'h99});
        drain("reset_mid");
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_bus_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL rst_bus: got %h need %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_store_fwd();
        test_back_to_back();
        test_load_miss();
        test_same_word();
        test_miss_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
